fp32_divider: RTL and testbench

Sequential IEEE-754 single-precision divider, quotient_o = a_i / b_i. It is the inverse-operation companion of the team's FP32 multiplier and shares its start/done handshake and flag set. The mantissa quotient comes from a bit-serial restoring divider, one quotient bit per clock, followed by round-to-nearest-even. It sits beside the multiplier in the FP datapath and is driven by the same controller.

---
 rtl/fp32_pkg.sv | 31 +++
 rtl/fp32_mant_div.sv | 58 +++++
 rtl/fp32_divider.sv | 175 +++++++++++++++++
 tb/tb_fp32_divider.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the divider and multiplier: FSM states, operand classes, field widths.
package fp32_pkg;

  localparam int FP_BIAS = 127;
  localparam int EXP_W   = 8;
  localparam int MANT_W  = 23;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_DIVIDE, S_NORMALIZE, S_ROUND, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN
  } fp_cls_e;

  // Denormals are flushed, so any zero exponent classifies as ZERO.
  function automatic fp_cls_e fp_classify(input logic [31:0] x);
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
    e = x[MANT_W +: EXP_W];
    m = x[MANT_W-1:0];
    if (e == '0)
      return CLS_ZERO;
    else if (e == '1)
      return (m == '0) ? CLS_INF : CLS_NAN;
    else
      return CLS_NORM;
  endfunction

endpackage

// File: rtl/fp32_mant_div.sv
// Bit-serial restoring mantissa divider: one quotient bit per clock, 26 bits after a load.
// valid_o rises on the edge that shifts in the last quotient bit and stays high until the next load.
module fp32_mant_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [25:0] dividend_i,
  input  logic [23:0] divisor_i,
  output logic [25:0] quotient_o,
  output logic        rem_nz_o,
  output logic        valid_o
);

  logic [25:0] rem_q, rem_d, rem_sub;
  logic [23:0] div_q;
  logic [25:0] quo_q;
  logic [4:0]  cnt_q;
  logic        run_q, valid_q;
  logic        q_bit;

  always_comb begin
    q_bit   = (rem_q >= {2'b00, div_q});
    rem_sub = q_bit ? (rem_q - {2'b00, div_q}) : rem_q;
    // rem_sub < divisor < 2^24, so the shift cannot drop a set bit.
    rem_d   = {rem_sub[24:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      rem_q   <= dividend_i;
      div_q   <= divisor_i;
      quo_q   <= '0;
      cnt_q   <= 5'd25;
      run_q   <= 1'b1;
      valid_q <= 1'b0;
    end else if (run_q) begin
      rem_q <= rem_d;
      quo_q <= {quo_q[24:0], q_bit};
      cnt_q <= cnt_q - 5'd1;
      if (cnt_q == 5'd0) begin
        run_q   <= 1'b0;
        valid_q <= 1'b1;
      end
    end
  end

  assign quotient_o = quo_q;
  assign rem_nz_o   = (rem_q != '0);
  assign valid_o    = valid_q;

endmodule

// File: rtl/fp32_divider.sv
// Sequential FP32 divider (a_i / b_i): 29 edges start-to-done for normal operands, 1 edge for special cases.
// start_i is honoured only in IDLE; done_o pulses one cycle and all results hold until the next start.
module fp32_divider
  import fp32_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] quotient_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        nan_o,
  output logic        infinit_o,
  output logic        div_by_zero_o,
  output logic        overflow_o,
  output logic        underflow_o
);

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d, quot_q, quot_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d, exp_r;
  logic [4:0]         cnt_q, cnt_d;
  logic [23:0]        mant_q, mant_d;
  logic               guard_q, guard_d, sticky_q, sticky_d;
  logic [4:0]         flag_q, flag_d;   // {nan, inf, div_by_zero, overflow, underflow}
  logic               done_q, busy_q;
  logic               core_load, core_rem_nz, core_vld, rnd_up;
  logic [25:0]        core_quo;
  logic [24:0]        mant_r;
  fp_cls_e            cls_a, cls_b;

  fp32_mant_div u_mant_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (core_load),
    .dividend_i ({2'b00, 1'b1, a_q[22:0]}),
    .divisor_i  ({1'b1, b_q[22:0]}),
    .quotient_o (core_quo),
    .rem_nz_o   (core_rem_nz),
    .valid_o    (core_vld)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    quot_d    = quot_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    mant_d    = mant_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    flag_d    = flag_q;
    core_load = 1'b0;
    cls_a     = fp_classify(a_q);
    cls_b     = fp_classify(b_q);
    rnd_up    = ROUND_EN && guard_q && (sticky_q || mant_q[0]);
    mant_r    = {1'b0, mant_q} + {24'd0, rnd_up};
    // A rounding carry leaves mant_r[22:0] zero, so only the exponent needs fixing.
    exp_r     = exp_q + {9'd0, mant_r[24]};

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          flag_d  = '0;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_d  = a_q[31] ^ b_q[31];
        state_d = S_DONE;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
            (cls_a == CLS_INF && cls_b == CLS_INF)) begin
          quot_d = FP_QNAN;
          flag_d = 5'b10000;
        end else if (cls_a == CLS_INF) begin
          quot_d = {sign_d, 8'hFF, 23'h0};
          flag_d = 5'b01000;
        end else if (cls_b == CLS_INF || cls_a == CLS_ZERO) begin
          quot_d = {sign_d, 31'h0};
        end else if (cls_b == CLS_ZERO) begin
          quot_d = {sign_d, 8'hFF, 23'h0};
          flag_d = 5'b00100;
        end else begin
          exp_d     = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]})
                      + $signed(10'(FP_BIAS));
          cnt_d     = 5'd25;
          core_load = 1'b1;
          state_d   = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0)
          state_d = S_NORMALIZE;
      end
      S_NORMALIZE: begin
        if (core_vld) begin
          if (core_quo[25]) begin
            mant_d   = core_quo[25:2];
            guard_d  = core_quo[1];
            sticky_d = core_quo[0] | core_rem_nz;
          end else begin
            mant_d   = core_quo[24:1];
            guard_d  = core_quo[0];
            sticky_d = core_rem_nz;
            exp_d    = exp_q - 10'sd1;
          end
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (exp_r >= 10'sd255) begin
          quot_d = {sign_q, 8'hFF, 23'h0};
          flag_d = 5'b00010;
        end else if (exp_r <= 10'sd0) begin
          quot_d = {sign_q, 31'h0};
          flag_d = 5'b00001;
        end else begin
          quot_d = {sign_q, exp_r[7:0], mant_r[22:0]};
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      quot_q   <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      cnt_q    <= '0;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      flag_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quot_q   <= quot_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      flag_q   <= flag_d;
      done_q   <= (state_d == S_DONE);
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign quotient_o = quot_q;
  assign done_o     = done_q;
  assign busy_o     = busy_q;
  assign {nan_o, infinit_o, div_by_zero_o, overflow_o, underflow_o} = flag_q;

endmodule

// File: tb/tb_fp32_divider.sv
// Scoreboard bench: a rounding and a truncating divider share stimulus; results are checked against an integer-division model.
module tb_fp32_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] a_i = '0, b_i = '0;
  logic [31:0] quo_r, quo_t;
  logic        done_r, busy_r, nan_r, inf_r, dbz_r, ovf_r, unf_r;
  logic        done_t, busy_t, nan_t, inf_t, dbz_t, ovf_t, unf_t;

  fp32_divider #(.ROUND_EN(1'b1)) dut_rnd (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .quotient_o(quo_r), .done_o(done_r), .busy_o(busy_r), .nan_o(nan_r),
    .infinit_o(inf_r), .div_by_zero_o(dbz_r), .overflow_o(ovf_r), .underflow_o(unf_r)
  );

  fp32_divider #(.ROUND_EN(1'b0)) dut_trn (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .quotient_o(quo_t), .done_o(done_t), .busy_o(busy_t), .nan_o(nan_t),
    .infinit_o(inf_t), .div_by_zero_o(dbz_t), .overflow_o(ovf_t), .underflow_o(unf_t)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a, b;
    logic [36:0] er, et;   // {nan, inf, dbz, ovf, unf, quotient}
    int          lat, t0;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference: exact integer division of the 24-bit significands, rounding from the remainder.
  function automatic logic [36:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit rnd);
    int     ea, eb, e;
    bit     sg, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    longint ma, mb, num, mant, rem;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sg = a[31] ^ b[31];
    a_zero = (ea == 0);   b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return {5'b10000, 32'h7FC00000};
    if (a_inf)  return {5'b01000, sg, 8'hFF, 23'h0};
    if (b_inf)  return {5'b00000, sg, 31'h0};
    if (b_zero) return {5'b00100, sg, 8'hFF, 23'h0};
    if (a_zero) return {5'b00000, sg, 31'h0};
    ma = 64'h80_0000 + longint'(a[22:0]);
    mb = 64'h80_0000 + longint'(b[22:0]);
    e  = ea - eb + 127;
    if (ma >= mb) num = ma << 23;
    else begin num = ma << 24; e = e - 1; end
    mant = num / mb;
    rem  = num % mb;
    if (rnd && ((2 * rem > mb) || ((2 * rem == mb) && (mant % 2 == 1)))) mant = mant + 1;
    if (mant == 64'h100_0000) begin mant = 64'h80_0000; e = e + 1; end
    if (e >= 255) return {5'b00010, sg, 8'hFF, 23'h0};
    if (e <= 0)   return {5'b00001, sg, 31'h0};
    return {5'b00000, sg, e[7:0], mant[22:0]};
  endfunction

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) || (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
  endfunction

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.a = a;  e.b = b;
    e.er = ref_div(a, b, 1'b1);
    e.et = ref_div(a, b, 1'b0);
    e.lat = is_special(a, b) ? 1 : 29;
    e.t0 = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy_r !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    a_i = a;  b_i = b;  start_i = 1'b1;
    push_exp(a, b);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_op();
    int r;
    logic [31:0] m;
    r = $urandom_range(0, 9);
    m = $urandom;
    case (r)
      0: return {m[31], 31'h0};
      1: return {m[31], 8'hFF, 23'h0};
      2: return {m[31], 8'hFF, m[22:1], 1'b1};
      3: return {m[31], 8'h00, m[22:0]};
      4, 5: return {m[31], 8'($urandom_range(1, 254)), m[22:0]};
      default: return {m[31], 8'($urandom_range(100, 154)), m[22:0]};
    endcase
  endfunction

  // Monitor: pops one expectation per done pulse from both dividers.
  initial begin : monitor
    exp_t e;
    bit   prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
        continue;
      end
      if (prev) chk("done_pulse_width", done_r, 0);
      if (done_r || done_t) begin
        if (sbq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sbq.pop_front();
          chk($sformatf("quot_rnd %h/%h", e.a, e.b), quo_r, e.er[31:0]);
          chk($sformatf("flags_rnd %h/%h", e.a, e.b), {nan_r, inf_r, dbz_r, ovf_r, unf_r}, e.er[36:32]);
          chk($sformatf("quot_trunc %h/%h", e.a, e.b), quo_t, e.et[31:0]);
          chk($sformatf("flags_trunc %h/%h", e.a, e.b), {nan_t, inf_t, dbz_t, ovf_t, unf_t}, e.et[36:32]);
          chk($sformatf("latency %h/%h", e.a, e.b), cyc - e.t0, e.lat);
          chk("done_sync", {done_r, done_t}, 2'b11);
          chk("busy_in_done", {busy_r, busy_t}, 2'b11);
        end
      end
      prev = done_r;
    end
  end

  logic [31:0] dir_a[13] = '{32'h40C00000, 32'h3F800000, 32'hC0C00000, 32'h3F800000, 32'h00000000,
                             32'h7F800000, 32'h7F000000, 32'h00800000, 32'h7FC00001, 32'h3F800000,
                             32'h80000000, 32'hFF800000, 32'h00000001};
  logic [31:0] dir_b[13] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h00000000, 32'h00000000,
                             32'h3F800000, 32'h3E800000, 32'h40000000, 32'h3F800000, 32'h7F800000,
                             32'h3F800000, 32'h7F800000, 32'h3F800000};

  initial begin : stim
    int k;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {quo_r, done_r, busy_r, nan_r, inf_r, dbz_r, ovf_r, unf_r}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) issue(dir_a[i], dir_b[i]);
    for (int i = 0; i < 60; i++) issue(rand_op(), rand_op());

    // start_i held high across a whole divide with operands changing mid-DIVIDE.
    wait_idle();
    a_i = 32'h40C00000;  b_i = 32'h40000000;  start_i = 1'b1;
    push_exp(a_i, b_i);
    repeat (12) @(negedge clk);
    a_i = $urandom;  b_i = $urandom;
    issue(32'h3F800000, 32'h40400000);

    // Asynchronous reset in the middle of a divide.
    wait_idle();
    a_i = 32'h40C00000;  b_i = 32'h40000000;  start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    chk("busy_before_reset", busy_r, 1);
    #2 rst_n = 1'b0;
    #1 chk("reset_async_outputs", {quo_r, done_r, busy_r, nan_r, inf_r, dbz_r, ovf_r, unf_r, quo_t, done_t, busy_t}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'h40C00000, 32'h40000000);

    k = 0;
    while (sbq.size() > 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("scoreboard_drained", sbq.size(), 0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
